// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: register-file word and select widths, and the
// grant encoding used by the writeback arbiter.
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_A    = 2'd1,
        GRANT_B    = 2'd2
    } arb_grant_t;

    localparam regbits_t REG_ZERO = 5'd0;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback request bundle for the two sources (A: pipeline, B: late returns).
// Sources use the master modport, the arbiter uses the slave modport.
interface regfile_write_arbiter_if;
    import cpu_types_pkg::*;

    logic     a_valid;
    logic     a_ready;
    regbits_t a_sel;
    word_t    a_dat;
    logic     b_valid;
    logic     b_ready;
    regbits_t b_sel;
    word_t    b_dat;

    modport master (
        output a_valid, a_sel, a_dat, b_valid, b_sel, b_dat,
        input  a_ready, b_ready
    );

    modport slave (
        input  a_valid, a_sel, a_dat, b_valid, b_sel, b_dat,
        output a_ready, b_ready
    );
endinterface

// File: rtl/wb_skid_slot.sv
// One-entry writeback holding slot with fall-through ready; writes to
// register 0 are accepted by the handshake but never occupy the slot.
module wb_skid_slot
    import cpu_types_pkg::*;
(
    input  logic     CLK,
    input  logic     nRST,
    input  logic     in_valid,
    input  regbits_t in_sel,
    input  word_t    in_dat,
    input  logic     grant,
    output logic     in_ready,
    output logic     capture,
    output logic     pend,
    output regbits_t sel,
    output word_t    dat
);
    logic     pend_q, pend_d;
    regbits_t sel_q, sel_d;
    word_t    dat_q, dat_d;

    assign in_ready = !pend_q || grant;
    assign capture  = in_valid && in_ready && (in_sel != REG_ZERO);
    assign pend     = pend_q;
    assign sel      = sel_q;
    assign dat      = dat_q;

    // Next-state: a refill wins over the clear caused by a grant.
    always_comb begin
        pend_d = pend_q;
        sel_d  = sel_q;
        dat_d  = dat_q;
        if (capture) begin
            pend_d = 1'b1;
            sel_d  = in_sel;
            dat_d  = in_dat;
        end else if (grant) begin
            pend_d = 1'b0;
        end else begin
            pend_d = pend_q;
        end
    end

    // Slot state registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pend_q <= 1'b0;
            sel_q  <= 5'd0;
            dat_q  <= 32'd0;
        end else begin
            pend_q <= pend_d;
            sel_q  <= sel_d;
            dat_q  <= dat_d;
        end
    end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Two-source register-file write arbiter: fixed priority to A with a B
// starvation limit, same-register ordering by age, registered write port.
// Optional write-to-read forwarding is enabled by REGFILE_ARB_BYPASS_EN.
module regfile_write_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic                    CLK,
    input  logic                    nRST,
    regfile_write_arbiter_if.slave  src,
    output logic                    rf_WEN,
    output regbits_t                rf_wsel,
    output word_t                   rf_wdat,
    input  regbits_t                rsel1,
    input  regbits_t                rsel2,
    input  word_t                   rdat1_raw,
    input  word_t                   rdat2_raw,
    output word_t                   rdat1,
    output word_t                   rdat2,
    output logic                    busy
);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic       pend_a_s, pend_b_s, cap_a_s, cap_b_s;
    regbits_t   sel_a_s, sel_b_s;
    word_t      dat_a_s, dat_b_s;
    arb_grant_t grant_s;
    logic       grant_a_s, grant_b_s;

    logic       b_older_q, b_older_d;
    logic [3:0] starve_q, starve_d;
    logic       wen_q, wen_d;
    regbits_t   wsel_q, wsel_d;
    word_t      wdat_q, wdat_d;

    assign grant_a_s = (grant_s == GRANT_A);
    assign grant_b_s = (grant_s == GRANT_B);

    wb_skid_slot u_slot_a (
        .CLK(CLK), .nRST(nRST),
        .in_valid(src.a_valid), .in_sel(src.a_sel), .in_dat(src.a_dat),
        .grant(grant_a_s), .in_ready(src.a_ready), .capture(cap_a_s),
        .pend(pend_a_s), .sel(sel_a_s), .dat(dat_a_s)
    );

    wb_skid_slot u_slot_b (
        .CLK(CLK), .nRST(nRST),
        .in_valid(src.b_valid), .in_sel(src.b_sel), .in_dat(src.b_dat),
        .grant(grant_b_s), .in_ready(src.b_ready), .capture(cap_b_s),
        .pend(pend_b_s), .sel(sel_b_s), .dat(dat_b_s)
    );

    // Arbitration: same-register conflicts go by age so the younger value lands last.
    always_comb begin
        grant_s = GRANT_NONE;
        case ({pend_a_s, pend_b_s})
            2'b10:   grant_s = GRANT_A;
            2'b01:   grant_s = GRANT_B;
            2'b11: begin
                if (sel_a_s == sel_b_s) begin
                    grant_s = b_older_q ? GRANT_B : GRANT_A;
                end else if (starve_q == STARVE_LIM) begin
                    grant_s = GRANT_B;
                end else begin
                    grant_s = GRANT_A;
                end
            end
            default: grant_s = GRANT_NONE;
        endcase
    end

    // Starvation counter, age flag and write-port next state.
    always_comb begin
        starve_d  = starve_q;
        b_older_d = b_older_q;
        wen_d     = 1'b0;
        wsel_d    = wsel_q;
        wdat_d    = wdat_q;

        if (grant_b_s || !pend_b_s) begin
            starve_d = 4'd0;
        end else if (grant_a_s && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + 4'd1;
        end else begin
            starve_d = starve_q;
        end

        if (cap_a_s && cap_b_s) begin
            b_older_d = 1'b1;
        end else if (cap_b_s && !pend_a_s) begin
            b_older_d = 1'b1;
        end else if (cap_a_s && pend_b_s) begin
            b_older_d = 1'b0;
        end else begin
            b_older_d = b_older_q;
        end

        case (grant_s)
            GRANT_A: begin
                wen_d  = 1'b1;
                wsel_d = sel_a_s;
                wdat_d = dat_a_s;
            end
            GRANT_B: begin
                wen_d  = 1'b1;
                wsel_d = sel_b_s;
                wdat_d = dat_b_s;
            end
            default: begin
                wen_d  = 1'b0;
                wsel_d = wsel_q;
                wdat_d = wdat_q;
            end
        endcase
    end

    // Arbiter state and registered write port.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            starve_q  <= 4'd0;
            b_older_q <= 1'b0;
            wen_q     <= 1'b0;
            wsel_q    <= 5'd0;
            wdat_q    <= 32'd0;
        end else begin
            starve_q  <= starve_d;
            b_older_q <= b_older_d;
            wen_q     <= wen_d;
            wsel_q    <= wsel_d;
            wdat_q    <= wdat_d;
        end
    end

    assign rf_WEN  = wen_q;
    assign rf_wsel = wsel_q;
    assign rf_wdat = wdat_q;
    assign busy    = pend_a_s || pend_b_s || wen_q;

`ifdef REGFILE_ARB_BYPASS_EN
    // Forward the write being committed so readers see it one cycle early.
    assign rdat1 = (wen_q && (wsel_q == rsel1) && (rsel1 != REG_ZERO)) ? wdat_q : rdat1_raw;
    assign rdat2 = (wen_q && (wsel_q == rsel2) && (rsel2 != REG_ZERO)) ? wdat_q : rdat2_raw;
`else
    logic unused_rsel_s;
    assign unused_rsel_s = ^{rsel1, rsel2};
    assign rdat1 = rdat1_raw;
    assign rdat2 = rdat2_raw;
`endif
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a behavioural register file
// fed from the write port.
module tb_regfile_write_arbiter;
    import cpu_types_pkg::*;

    logic     CLK = 1'b0;
    logic     nRST;
    logic     rf_WEN, busy;
    regbits_t rf_wsel, rsel1, rsel2;
    word_t    rf_wdat, rdat1_raw, rdat2_raw, rdat1, rdat2;

    int vectors = 0;
    int miscompares = 0;

    word_t rf_model [32] = '{default: 32'h0};

    regfile_write_arbiter_if wb_if ();

    regfile_write_arbiter #(.STARVE_MAX(3)) dut (
        .CLK(CLK), .nRST(nRST), .src(wb_if),
        .rf_WEN(rf_WEN), .rf_wsel(rf_wsel), .rf_wdat(rf_wdat),
        .rsel1(rsel1), .rsel2(rsel2),
        .rdat1_raw(rdat1_raw), .rdat2_raw(rdat2_raw),
        .rdat1(rdat1), .rdat2(rdat2), .busy(busy)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (rf_WEN) rf_model[rf_wsel] <= rf_wdat;
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_wr(input string tag, input logic [4:0] sel, input logic [31:0] dat);
        check({tag, "_wen"}, {31'd0, rf_WEN}, 32'd1);
        check({tag, "_wsel"}, {27'd0, rf_wsel}, {27'd0, sel});
        check({tag, "_wdat"}, rf_wdat, dat);
    endtask

    task automatic drive_a(input logic v, input logic [4:0] s, input logic [31:0] d);
        wb_if.a_valid = v; wb_if.a_sel = s; wb_if.a_dat = d;
    endtask

    task automatic drive_b(input logic v, input logic [4:0] s, input logic [31:0] d);
        wb_if.b_valid = v; wb_if.b_sel = s; wb_if.b_dat = d;
    endtask

    initial begin
        nRST = 1'b0;
        drive_a(1'b0, 5'd0, 32'd0);
        drive_b(1'b0, 5'd0, 32'd0);
        rsel1 = 5'd0; rsel2 = 5'd0;
        rdat1_raw = 32'h1111; rdat2_raw = 32'h2222;
        #12;
        check("rst_wen", {31'd0, rf_WEN}, 32'd0);
        check("rst_wsel", {27'd0, rf_wsel}, 32'd0);
        check("rst_wdat", rf_wdat, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ready", {30'd0, wb_if.a_ready, wb_if.b_ready}, 32'd3);
        check("rst_rdat1", rdat1, 32'h1111);
        check("rst_rdat2", rdat2, 32'h2222);
        step();
        nRST = 1'b1;
        step();

        // A alone, back-to-back regs 1..8
        for (int i = 0; i < 8; i++) begin
            drive_a(1'b1, 5'(i + 1), 32'h10 + 32'(i));
            check("a_stream_ready", {31'd0, wb_if.a_ready}, 32'd1);
            step();
            if (i == 0) check("a_stream_lat", {31'd0, rf_WEN}, 32'd0);
            else check_wr("a_stream", 5'(i), 32'h10 + 32'(i - 1));
        end
        drive_a(1'b0, 5'd0, 32'd0);
        step();
        check_wr("a_stream_last", 5'd8, 32'h17);
        step();
        check("a_idle_wen", {31'd0, rf_WEN}, 32'd0);
        check("a_idle_hold_sel", {27'd0, rf_wsel}, 32'd8);
        check("a_idle_hold_dat", rf_wdat, 32'h17);
        check("a_idle_busy", {31'd0, busy}, 32'd0);
        check("rf_reg8", rf_model[8], 32'h17);
        check("rf_reg1", rf_model[1], 32'h10);

        // Starvation: A streams to reg 3 while B (reg 9) waits
        drive_a(1'b1, 5'd3, 32'h100);
        drive_b(1'b1, 5'd9, 32'hBEEF);
        step();
        drive_b(1'b0, 5'd0, 32'd0);
        wb_if.a_dat = 32'h101;
        check("st_lat", {31'd0, rf_WEN}, 32'd0);
        check("st_busy", {31'd0, busy}, 32'd1);
        step();
        check_wr("st_a0", 5'd3, 32'h100);
        wb_if.a_dat = 32'h102;
        step();
        check_wr("st_a1", 5'd3, 32'h101);
        wb_if.a_dat = 32'h103;
        step();
        check_wr("st_a2", 5'd3, 32'h102);
        check("st_a_blocked", {31'd0, wb_if.a_ready}, 32'd0);
        wb_if.a_dat = 32'h104;
        drive_b(1'b1, 5'd3, 32'hB2);
        check("st_b_refill_ready", {31'd0, wb_if.b_ready}, 32'd1);
        step();
        check_wr("st_b_forced", 5'd9, 32'hBEEF);
        drive_b(1'b0, 5'd0, 32'd0);
        check("st_a_ready_again", {31'd0, wb_if.a_ready}, 32'd1);
        step();
        check_wr("st_a3_older", 5'd3, 32'h103);
        drive_a(1'b0, 5'd0, 32'd0);
        step();
        check_wr("st_a4_older", 5'd3, 32'h104);
        step();
        check_wr("st_b_same_reg", 5'd3, 32'hB2);
        step();
        check("st_idle_wen", {31'd0, rf_WEN}, 32'd0);
        check("st_idle_busy", {31'd0, busy}, 32'd0);
        check("st_reg3", rf_model[3], 32'hB2);
        check("st_reg9", rf_model[9], 32'hBEEF);

        // Same-register ordering: B then A
        drive_b(1'b1, 5'd5, 32'h1);
        step();
        drive_b(1'b0, 5'd0, 32'd0);
        drive_a(1'b1, 5'd5, 32'h2);
        step();
        check_wr("ord_ba_first", 5'd5, 32'h1);
        drive_a(1'b0, 5'd0, 32'd0);
        step();
        check_wr("ord_ba_second", 5'd5, 32'h2);
        step();
        check("ord_ba_reg5", rf_model[5], 32'h2);

        // Same-register ordering: A then B
        drive_a(1'b1, 5'd5, 32'h2);
        step();
        drive_a(1'b0, 5'd0, 32'd0);
        drive_b(1'b1, 5'd5, 32'h1);
        step();
        check_wr("ord_ab_first", 5'd5, 32'h2);
        drive_b(1'b0, 5'd0, 32'd0);
        step();
        check_wr("ord_ab_second", 5'd5, 32'h1);
        step();
        check("ord_ab_reg5", rf_model[5], 32'h1);

        // Same-register, same edge: B counts as older
        drive_a(1'b1, 5'd5, 32'h2);
        drive_b(1'b1, 5'd5, 32'h1);
        step();
        drive_a(1'b0, 5'd0, 32'd0);
        drive_b(1'b0, 5'd0, 32'd0);
        step();
        check_wr("ord_tie_first", 5'd5, 32'h1);
        step();
        check_wr("ord_tie_second", 5'd5, 32'h2);
        step();
        check("ord_tie_reg5", rf_model[5], 32'h2);

        // Register 0 writes are swallowed
        drive_a(1'b1, 5'd0, 32'hDEAD);
        drive_b(1'b1, 5'd0, 32'hBEEF);
        check("z_ready", {30'd0, wb_if.a_ready, wb_if.b_ready}, 32'd3);
        step();
        check("z_ready_after", {30'd0, wb_if.a_ready, wb_if.b_ready}, 32'd3);
        check("z_busy", {31'd0, busy}, 32'd0);
        step();
        drive_a(1'b0, 5'd0, 32'd0);
        drive_b(1'b0, 5'd0, 32'd0);
        check("z_wen", {31'd0, rf_WEN}, 32'd0);
        check("z_busy2", {31'd0, busy}, 32'd0);
        check("z_hold_sel", {27'd0, rf_wsel}, 32'd5);
        check("z_reg0", rf_model[0], 32'd0);

        // Reset while both slots full and a write in flight
        drive_a(1'b1, 5'd10, 32'hA1);
        drive_b(1'b1, 5'd11, 32'hB1);
        step();
        drive_b(1'b0, 5'd0, 32'd0);
        drive_a(1'b1, 5'd12, 32'hA2);
        step();
        check_wr("rst_mid_pre", 5'd10, 32'hA1);
        nRST = 1'b0;
        #1;
        check("rst_mid_wen", {31'd0, rf_WEN}, 32'd0);
        check("rst_mid_wsel", {27'd0, rf_wsel}, 32'd0);
        check("rst_mid_wdat", rf_wdat, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_ready", {30'd0, wb_if.a_ready, wb_if.b_ready}, 32'd3);
        drive_a(1'b0, 5'd0, 32'd0);
        step();
        nRST = 1'b1;
        step();
        check("rst_post_wen", {31'd0, rf_WEN}, 32'd0);
        step();
        check("rst_post_wen2", {31'd0, rf_WEN}, 32'd0);
        check("rst_post_reg11", rf_model[11], 32'd0);
        check("rst_post_reg12", rf_model[12], 32'd0);
        check("rst_post_busy", {31'd0, busy}, 32'd0);

        // Read path with a committed write to reg 7
        drive_a(1'b1, 5'd7, 32'hCAFE);
        step();
        drive_a(1'b0, 5'd0, 32'd0);
        step();
        check_wr("byp_wr", 5'd7, 32'hCAFE);
        rsel1 = 5'd7; rdat1_raw = 32'h0;
        rsel2 = 5'd7; rdat2_raw = 32'h55;
        #1;
`ifdef REGFILE_ARB_BYPASS_EN
        check("byp_rdat1_hit", rdat1, 32'hCAFE);
        check("byp_rdat2_hit", rdat2, 32'hCAFE);
`else
        check("byp_rdat1_raw", rdat1, 32'h0);
        check("byp_rdat2_raw", rdat2, 32'h55);
`endif
        rsel1 = 5'd0; rdat1_raw = 32'h1234;
        rsel2 = 5'd6; rdat2_raw = 32'h5678;
        #1;
        check("byp_rsel0", rdat1, 32'h1234);
        check("byp_rsel_miss", rdat2, 32'h5678);
        rsel1 = 5'd7; rdat1_raw = 32'h9;
        step();
        check("byp_no_wen", rdat1, 32'h9);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
